// File: rtl/drp_resp_pkg.sv
// Shared widths and FSM encoding for the DRP responder.
package drp_resp_pkg;

    localparam int DRP_AW = 5;
    localparam int DRP_DW = 16;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } drp_state_e;

endpackage

// File: rtl/drp_lock_timer.sv
// Emulated PLL lock: LOCKED rises after LOCK_DLY consecutive RST_PLL-low edges.
module drp_lock_timer #(
    parameter int LOCK_DLY = 64
) (
    input  logic CLK,
    input  logic RSTX,
    input  logic RST_PLL,
    output logic LOCKED
);

    localparam logic [15:0] LOCK_MAX = 16'(LOCK_DLY);

    logic [15:0] r_cnt;
    logic        r_locked;
    logic [15:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (RST_PLL) begin
            w_cnt_next = '0;
        end else if (r_cnt != LOCK_MAX) begin
            w_cnt_next = r_cnt + 16'd1;
        end
    end

    // LOCKED follows the next count so it rises on the edge the count saturates.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_locked <= (w_cnt_next == LOCK_MAX);
        end
    end

    assign LOCKED = r_locked;

endmodule

// File: rtl/drp_resp.sv
// DRP responder: 32x16 register bank with fixed DRDY latency and PLL lock emulation.
// Optional protocol check of DEN-while-busy is built when DRP_RESP_ERRCHK_EN is defined.
module drp_resp
    import drp_resp_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter int LOCK_DLY = 64
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic              DEN,
    input  logic              DWE,
    input  logic [DRP_AW-1:0] DADDR,
    input  logic [DRP_DW-1:0] DI,
    output logic [DRP_DW-1:0] DO,
    output logic              DRDY,
    input  logic              RST_PLL,
    output logic              LOCKED,
    output logic              ERR
);

    localparam int NREG = 1 << DRP_AW;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    drp_state_e        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [DRP_AW-1:0] r_addr;
    logic [DRP_DW-1:0] r_data;
    logic              r_we;
    logic              r_drdy, w_drdy_next;
    logic [DRP_DW-1:0] r_do, w_do_next;
    logic              w_capture;
    logic              w_mem_we;
    logic [DRP_DW-1:0] r_mem [NREG];

    // The DRDY cycle is still BUSY, so a DEN there is dropped like any other overlap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_drdy_next  = 1'b0;
        w_do_next    = r_do;
        w_capture    = 1'b0;
        w_mem_we     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (DEN) begin
                    w_state_next = ST_BUSY;
                    w_cnt_next   = LAT_LOAD;
                    w_capture    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (r_drdy) begin
                    w_state_next = ST_IDLE;
                    w_mem_we     = r_we;
                end else if (r_cnt == '0) begin
                    w_drdy_next = 1'b1;
                    if (!r_we) begin
                        w_do_next = r_mem[r_addr];
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_drdy  <= 1'b0;
            r_do    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_drdy  <= w_drdy_next;
            r_do    <= w_do_next;
            if (w_capture) begin
                r_addr <= DADDR;
                r_data <= DI;
                r_we   <= DWE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bank
            always_ff @(posedge CLK or negedge RSTX) begin
                if (!RSTX) begin
                    r_mem[gi] <= '0;
                end else if (w_mem_we && (r_addr == DRP_AW'(gi))) begin
                    r_mem[gi] <= r_data;
                end
            end
        end
    endgenerate

`ifdef DRP_RESP_ERRCHK_EN
    logic r_err;
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_err <= 1'b0;
        end else if (DEN && (r_state == ST_BUSY)) begin
            r_err <= 1'b1;
        end
    end
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    drp_lock_timer #(
        .LOCK_DLY(LOCK_DLY)
    ) u_lock (
        .CLK    (CLK),
        .RSTX   (RSTX),
        .RST_PLL(RST_PLL),
        .LOCKED (LOCKED)
    );

    assign DO   = r_do;
    assign DRDY = r_drdy;

endmodule

// File: tb/tb_drp_resp.sv
// Directed bench for drp_resp: table-driven transactions plus hand-written
// overlap, latency-sweep, reset-abort and lock sequences.
module tb_drp_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        den, dwe, rst_pll;
    logic [4:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy, locked, err;

    logic        den_a, dwe_a;
    logic [4:0]  daddr_a;
    logic [15:0] di_a;
    logic [15:0] do_l1, do_l15;
    logic        drdy_l1, drdy_l15, locked_l1, locked_l15, err_l1, err_l15;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    drp_resp #(.RD_LAT(LAT), .LOCK_DLY(64)) dut (
        .CLK(clk), .RSTX(rst_n), .DEN(den), .DWE(dwe), .DADDR(daddr), .DI(di),
        .DO(dout), .DRDY(drdy), .RST_PLL(rst_pll), .LOCKED(locked), .ERR(err)
    );

    drp_resp #(.RD_LAT(1), .LOCK_DLY(64)) dut_l1 (
        .CLK(clk), .RSTX(rst_n), .DEN(den_a), .DWE(dwe_a), .DADDR(daddr_a), .DI(di_a),
        .DO(do_l1), .DRDY(drdy_l1), .RST_PLL(rst_pll), .LOCKED(locked_l1), .ERR(err_l1)
    );

    drp_resp #(.RD_LAT(15), .LOCK_DLY(64)) dut_l15 (
        .CLK(clk), .RSTX(rst_n), .DEN(den_a), .DWE(dwe_a), .DADDR(daddr_a), .DI(di_a),
        .DO(do_l15), .DRDY(drdy_l15), .RST_PLL(rst_pll), .LOCKED(locked_l15), .ERR(err_l15)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_do;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on the main DUT; checks DRDY offset, read data and pulse width.
    task automatic txn(input logic we, input logic [4:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_do, input string name);
        int lat;
        @(negedge clk);
        den = 1'b1; dwe = we; daddr = addr; di = wdata;
        @(negedge clk);
        den = 1'b0;
        lat = 0;
        while (!drdy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, LAT);
        if (!we) chk({name, " DO"}, {16'h0, dout}, {16'h0, exp_do});
        @(negedge clk);
        chk({name, " drdy pulse"}, {31'h0, drdy}, 32'h0);
        $display("txn %s we=%0b addr=%02h wdata=%04h do=%04h lat=%0d", name, we, addr, wdata, dout, lat);
    endtask

    initial begin
        int n_drdy, l1, l15;
        logic [15:0] cap_do, cap1, cap15;
        logic exp_err;
`ifdef DRP_RESP_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        vecs[0] = '{1'b1, 5'h08, 16'hA5C3, 16'h0000};
        vecs[1] = '{1'b0, 5'h08, 16'h0000, 16'hA5C3};
        vecs[2] = '{1'b0, 5'h1F, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 5'h00, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b0, 5'h00, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b1, 5'h1F, 16'h0001, 16'h0000};
        vecs[6] = '{1'b0, 5'h1F, 16'h0000, 16'h0001};
        vecs[7] = '{1'b0, 5'h08, 16'h0000, 16'hA5C3};

        rst_n = 1'b0; rst_pll = 1'b0;
        den = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
        den_a = 1'b0; dwe_a = 1'b0; daddr_a = '0; di_a = '0;
        repeat (3) @(negedge clk);
        chk("reset DO", {16'h0, dout}, 32'h0);
        chk("reset DRDY", {31'h0, drdy}, 32'h0);
        chk("reset LOCKED", {31'h0, locked}, 32'h0);
        chk("reset ERR", {31'h0, err}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_do, $sformatf("vec%0d", i));

        // Latency sweep on the RD_LAT=1 and RD_LAT=15 instances.
        @(negedge clk);
        den_a = 1'b1; dwe_a = 1'b0; daddr_a = 5'h1F;
        @(negedge clk);
        den_a = 1'b0;
        l1 = -1; l15 = -1; cap1 = 16'hxxxx; cap15 = 16'hxxxx;
        for (int k = 0; k < 40; k++) begin
            if (drdy_l1 && l1 < 0) begin l1 = k; cap1 = do_l1; end
            if (drdy_l15 && l15 < 0) begin l15 = k; cap15 = do_l15; end
            @(negedge clk);
        end
        chk("lat1 offset", l1, 1);
        chk("lat15 offset", l15, 15);
        chk("lat1 DO", {16'h0, cap1}, 32'h0);
        chk("lat15 DO", {16'h0, cap15}, 32'h0);
        $display("sweep lat1=%0d lat15=%0d", l1, l15);

        // Overlap: second DEN one cycle after a read's DEN must be dropped.
        chk("err before overlap", {31'h0, err}, 32'h0);
        @(negedge clk);
        den = 1'b1; dwe = 1'b0; daddr = 5'h08;
        @(negedge clk);
        den = 1'b1; dwe = 1'b1; daddr = 5'h08; di = 16'hDEAD;
        @(negedge clk);
        den = 1'b0;
        n_drdy = 0; cap_do = 16'h0;
        for (int k = 0; k < 20; k++) begin
            if (drdy) begin n_drdy++; cap_do = dout; end
            @(negedge clk);
        end
        chk("overlap drdy count", n_drdy, 1);
        chk("overlap DO", {16'h0, cap_do}, 32'h0000A5C3);
        chk("overlap ERR", {31'h0, err}, {31'h0, exp_err});
        $display("overlap drdy=%0d do=%04h err=%0b", n_drdy, cap_do, err);
        txn(1'b0, 5'h08, 16'h0, 16'hA5C3, "overlap bank");

        // Address wrap: every register holds its own value.
        for (int i = 0; i < 32; i++)
            txn(1'b1, 5'(i), 16'hC000 | 16'(i * 16'h0101), 16'h0, $sformatf("wr%0d", i));
        for (int i = 0; i < 32; i++)
            txn(1'b0, 5'(i), 16'h0, 16'hC000 | 16'(i * 16'h0101), $sformatf("rd%0d", i));

        // Reset one cycle after a write DEN aborts it.
        @(negedge clk);
        den = 1'b1; dwe = 1'b1; daddr = 5'h03; di = 16'h1234;
        @(negedge clk);
        den = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("abort DO", {16'h0, dout}, 32'h0);
        rst_n = 1'b1;
        chk("abort ERR", {31'h0, err}, 32'h0);
        chk("abort LOCKED", {31'h0, locked}, 32'h0);
        n_drdy = 0;
        for (int k = 0; k < 10; k++) begin
            if (drdy) n_drdy++;
            @(negedge clk);
        end
        chk("abort drdy count", n_drdy, 0);
        $display("abort drdy=%0d err=%0b locked=%0b", n_drdy, err, locked);
        txn(1'b0, 5'h03, 16'h0, 16'h0000, "abort read03");
        txn(1'b0, 5'h08, 16'h0, 16'h0000, "abort read08");

        // Lock: 10 cycles of RST_PLL, then 64 low edges to lock.
        @(negedge clk);
        rst_pll = 1'b1;
        repeat (10) @(negedge clk);
        chk("lock held in reset", {31'h0, locked}, 32'h0);
        rst_pll = 1'b0;
        repeat (63) @(negedge clk);
        chk("lock at 63", {31'h0, locked}, 32'h0);
        @(negedge clk);
        chk("lock at 64", {31'h0, locked}, 32'h1);
        txn(1'b1, 5'h05, 16'h5555, 16'h0, "locked write");
        txn(1'b0, 5'h05, 16'h0, 16'h5555, "locked read");
        chk("still locked", {31'h0, locked}, 32'h1);
        rst_pll = 1'b1;
        @(negedge clk);
        rst_pll = 1'b0;
        chk("pulse drop", {31'h0, locked}, 32'h0);
        repeat (63) @(negedge clk);
        chk("relock at 63", {31'h0, locked}, 32'h0);
        @(negedge clk);
        chk("relock at 64", {31'h0, locked}, 32'h1);
        $display("lock sequence locked=%0b", locked);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
